// File: rtl/opll_sample_mixer.sv
// Frame mixer for OPLL slot samples: sums SLOTS signed samples per frame,
// applies a power-of-two gain and saturates the result to a signed 16-bit output.
module opll_sample_mixer #(
  parameter int IN_W       = 9,
  parameter int SLOTS      = 18,
  parameter int GAIN_SHIFT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_first,
  input  logic [IN_W-1:0] in_data,
  input  logic            clip_clr,
  output logic [15:0]     out_sample,
  output logic            out_valid,
  output logic            out_clip,
  output logic            frame_err
);

  localparam int AW = IN_W + 5;
  localparam int SW = AW + GAIN_SHIFT + 17;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-32768);
  localparam logic [4:0] LAST_COUNT = 5'(SLOTS - 1);

  generate
    if (SLOTS < 2 || SLOTS > 31) begin : gSlotsCheck
      $error("opll_sample_mixer: SLOTS must be in 2..31");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, HUNT} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [4:0]             count_q, count_d;
  logic [15:0]            sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   clip_q, clip_d;
  logic                   err_q, err_d;

  logic signed [AW-1:0]   dataExt;
  logic signed [AW-1:0]   accPlus;
  logic signed [SW-1:0]   scaled;
  logic                   satHigh;
  logic                   satLow;
  logic [15:0]            satSample;

  // The working width is wide enough that the gain shift can never lose bits.
  assign dataExt   = $signed({{5{in_data[IN_W-1]}}, in_data});
  assign accPlus   = acc_q + dataExt;
  assign scaled    = $signed({{(SW-AW){accPlus[AW-1]}}, accPlus}) <<< GAIN_SHIFT;
  assign satHigh   = scaled > SAT_MAX;
  assign satLow    = scaled < SAT_MIN;
  assign satSample = satHigh ? 16'h7fff : (satLow ? 16'h8000 : scaled[15:0]);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    clip_d   = clip_clr ? 1'b0 : clip_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_first) begin
          acc_d   = dataExt;
          count_d = 5'd1;
          state_d = ACCUM;
        end
      end
      HUNT: begin
        if (in_valid) begin
          if (in_first) begin
            acc_d   = dataExt;
            count_d = 5'd1;
            state_d = ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (in_first) begin
            acc_d   = dataExt;
            count_d = 5'd1;
            err_d   = 1'b1;
          end else if (count_q == LAST_COUNT) begin
            // A saturating publish overrides a concurrent clip clear.
            sample_d = satSample;
            valid_d  = 1'b1;
            if (satHigh || satLow) begin
              clip_d = 1'b1;
            end
            acc_d   = '0;
            count_d = 5'd0;
            state_d = HUNT;
          end else begin
            acc_d   = accPlus;
            count_d = count_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= 5'd0;
      sample_q <= 16'd0;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
      err_q    <= err_d;
    end
  end

  assign out_sample = sample_q;
  assign out_valid  = valid_q;
  assign out_clip   = clip_q;
  assign frame_err  = err_q;

endmodule
